// File: rtl/truth_table_bist_pkg.sv
// Shared types and constants for the truth-table self-test checker.
package truth_table_bist_pkg;

    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned ERR_W   = 5;

    localparam logic [NUM_VEC-1:0] DEF_EXP_X = 16'hCF00;
    localparam logic [NUM_VEC-1:0] DEF_EXP_Y = 16'h0F54;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Accumulated sweep results, cleared together on every launch.
    typedef struct packed {
        logic [ERR_W-1:0]   err_count;
        logic [NUM_VEC-1:0] fail_mask;
        logic [IDX_W-1:0]   first_fail;
        logic               first_fail_vld;
    } result_t;

endpackage

// File: rtl/truth_table_bist_tt_compare.sv
// Truth-table lookup: flags a response that differs from the expected x/y for the applied vector.
module tt_compare
    import truth_table_bist_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] EXP_X = DEF_EXP_X,
    parameter logic [NUM_VEC-1:0] EXP_Y = DEF_EXP_Y
) (
    input  logic [IDX_W-1:0] stim,
    input  logic             resp_x,
    input  logic             resp_y,
    output logic             mismatch
);

    // Either output disagreeing with the table fails the vector.
    assign mismatch = (resp_x != EXP_X[stim]) || (resp_y != EXP_Y[stim]);

endmodule

// File: rtl/truth_table_bist.sv
// Exhaustive 16-vector sweep of a 4-in/2-out function with pass/fail reporting.
module truth_table_bist
    import truth_table_bist_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] EXP_X      = DEF_EXP_X,
    parameter logic [NUM_VEC-1:0] EXP_Y      = DEF_EXP_Y,
    parameter int unsigned        SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [IDX_W-1:0]     stim,
    input  logic                 resp_x,
    input  logic                 resp_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [NUM_VEC-1:0]   fail_mask,
    output logic [IDX_W-1:0]     first_fail,
    output logic                 first_fail_vld
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] SETTLE   = CNT_W'(SETTLE_CYC);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] stim_q, stim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    result_t          res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic launch;
    logic sample;
    logic mismatch;

    tt_compare #(
        .EXP_X (EXP_X),
        .EXP_Y (EXP_Y)
    ) u_cmp (
        .stim     (stim_q),
        .resp_x   (resp_x),
        .resp_y   (resp_y),
        .mismatch (mismatch)
    );

    // Start is honoured only when no sweep is in flight; sampling happens on the last settle cycle.
    assign launch = start && ((state_q == IDLE) || (state_q == DONE));
    assign sample = (state_q == RUN) && (cnt_q == SETTLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = RUN;
            RUN:     if (sample && (stim_q == LAST_IDX)) state_d = DONE;
            DONE:    if (launch) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: launch clears, each sample folds in one vector result.
    always_comb begin
        stim_d = stim_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;
        if (launch) begin
            stim_d = '0;
            cnt_d  = '0;
            res_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
            pass_d = 1'b0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (sample) begin
                cnt_d = '0;
                if (mismatch) begin
                    res_d.err_count         = res_q.err_count + ERR_W'(1);
                    res_d.fail_mask[stim_q] = 1'b1;
                    if (!res_q.first_fail_vld) begin
                        res_d.first_fail     = stim_q;
                        res_d.first_fail_vld = 1'b1;
                    end
                end
                if (stim_q != LAST_IDX) begin
                    stim_d = stim_q + IDX_W'(1);
                end else begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (res_d.err_count == '0);
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            stim_q <= stim_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign stim           = stim_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = res_q.err_count;
    assign fail_mask      = res_q.fail_mask;
    assign first_fail     = res_q.first_fail;
    assign first_fail_vld = res_q.first_fail_vld;

endmodule

// File: tb/tb_truth_table_bist.sv
// Randomized fault-injection bench for truth_table_bist against a mask-based reference model.
module tb_truth_table_bist;

    localparam logic [15:0] GOLD_X = 16'hCF00;
    localparam logic [15:0] GOLD_Y = 16'h0F54;
    localparam int          HOLD   = 3;   // SETTLE_CYC=2 -> 3 cycles per vector
    localparam int          HOLD1  = 2;   // SETTLE_CYC=1

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  stim;
    logic        resp_x, resp_y;
    logic        busy, done, pass;
    logic [4:0]  err_count;
    logic [15:0] fail_mask;
    logic [3:0]  first_fail;
    logic        first_fail_vld;

    logic        start1 = 1'b0;
    logic [3:0]  stim1;
    logic        resp_x1, resp_y1;
    logic        busy1, done1, pass1;
    logic [4:0]  err_count1;
    logic [15:0] fail_mask1;
    logic [3:0]  first_fail1;
    logic        first_fail_vld1;

    logic [15:0] flip_x = '0;
    logic [15:0] flip_y = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Function under test: the correct table with per-vector output flips injected.
    assign resp_x  = GOLD_X[stim] ^ flip_x[stim];
    assign resp_y  = GOLD_Y[stim] ^ flip_y[stim];
    assign resp_x1 = GOLD_X[stim1];
    assign resp_y1 = GOLD_Y[stim1];

    truth_table_bist #(.EXP_X(GOLD_X), .EXP_Y(GOLD_Y), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim),
        .resp_x(resp_x), .resp_y(resp_y), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_mask(fail_mask), .first_fail(first_fail),
        .first_fail_vld(first_fail_vld)
    );

    truth_table_bist #(.EXP_X(GOLD_X), .EXP_Y(GOLD_Y), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stim(stim1),
        .resp_x(resp_x1), .resp_y(resp_y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .fail_mask(fail_mask1), .first_fail(first_fail1),
        .first_fail_vld(first_fail_vld1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest_set(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return 0;
    endfunction

    // One sweep on dut. restart_at: cycle to pulse start mid-run; abort_at: cycle to assert reset.
    task automatic run_sweep(input logic [15:0] fx, input logic [15:0] fy,
                             input int restart_at, input int abort_at);
        logic [15:0] bad;
        logic [15:0] seen;
        bad = fx | fy;
        @(negedge clk);
        flip_x = fx;
        flip_y = fy;
        start  = 1'b1;
        @(negedge clk);                       // just after E0
        start = 1'b0;
        check("launch_done_clr", done, 0);
        check("launch_err_clr", err_count, 0);
        check("launch_mask_clr", fail_mask, 0);
        check("launch_ffv_clr", first_fail_vld, 0);
        for (int k = 0; k < NUM_CYC(); k++) begin
            if (k > 0) begin
                @(negedge clk);
                start = (k == restart_at);
            end
            seen = 16'((32'd1 << (k / HOLD)) - 1);
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("run_stim", stim, k / HOLD);
            check("run_err", err_count, $countones(bad & seen));
            check("run_mask", fail_mask, bad & seen);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", busy, 0);
                check("abort_stim", stim, 0);
                check("abort_err", err_count, 0);
                check("abort_mask", fail_mask, 0);
                check("abort_ffv", first_fail_vld, 0);
                check("abort_done", done, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        @(negedge clk);                       // just after E0+48
        start = 1'b0;
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_stim", stim, 15);
        check("end_pass", pass, bad == 16'h0);
        check("end_err", err_count, $countones(bad));
        check("end_mask", fail_mask, bad);
        check("end_ff", first_fail, lowest_set(bad));
        check("end_ffv", first_fail_vld, bad != 16'h0);
        // DONE holds its results while start stays low.
        repeat (3) @(negedge clk);
        check("hold_done", done, 1);
        check("hold_err", err_count, $countones(bad));
    endtask

    function automatic int NUM_CYC();
        return 16 * HOLD;
    endfunction

    initial begin
        logic [15:0] rx, ry;
        repeat (3) @(negedge clk);
        check("rst_stim", stim, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_mask", fail_mask, 0);
        check("rst_ff", first_fail, 0);
        check("rst_ffv", first_fail_vld, 0);
        check("rst_busy1", busy1, 0);
        rst_n = 1'b1;

        run_sweep(16'h0000, 16'h0000, -1, -1);          // correct function
        run_sweep(GOLD_X,   16'h0000, -1, -1);          // x stuck at 0
        run_sweep(16'h0000, 16'hFFFF, -1, -1);          // y inverted
        run_sweep(16'h0420, 16'h0000, 5 * HOLD, -1);    // start mid-run ignored
        run_sweep(16'h0000, 16'h8001, -1, -1);          // restart from DONE
        run_sweep(16'hFFFF, 16'h0000, -1, 9 * HOLD);    // reset abort at vector 9
        run_sweep(16'h0000, 16'h0000, -1, -1);          // clean run after abort

        for (int r = 0; r < 6; r++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            if (r % 2 == 1) begin
                rx = rx & 16'($urandom) & 16'($urandom);
                ry = ry & 16'($urandom) & 16'($urandom);
            end
            if (r == 4) ry = 16'h0;
            run_sweep(rx, ry, (r == 2) ? int'($urandom_range(1, 46)) : -1, -1);
        end

        // Free-run on the SETTLE_CYC=1 instance with start held high.
        @(negedge clk);
        start1 = 1'b1;
        for (int k = 0; k <= 16 * HOLD1 + 1; k++) begin
            @(negedge clk);
            if (k < 16 * HOLD1) begin
                check("fr_busy", busy1, 1);
                check("fr_stim", stim1, k / HOLD1);
            end else if (k == 16 * HOLD1) begin
                check("fr_done", done1, 1);
                check("fr_pass", pass1, 1);
                check("fr_busy_lo", busy1, 0);
                check("fr_err", err_count1, 0);
                check("fr_ffv", first_fail_vld1, 0);
            end else begin
                check("fr_restart_busy", busy1, 1);
                check("fr_restart_done", done1, 0);
                check("fr_restart_stim", stim1, 0);
                check("fr_restart_pass", pass1, 0);
            end
        end
        start1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
